// File: rtl/expr_chk_pkg.sv
// -----------------------------------------------------------------------------
// expr_chk_pkg
// Shared definitions for the expression-check sequencer:
//   - sequencer state encoding
//   - operand field layout of the packed stimulus bus
//     {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}, a0 in the MSBs
//   - 64-bit Fibonacci LFSR tap mask (taps 64,63,61,60) and default seed
//   - lfsr_step(): one LFSR shift
// -----------------------------------------------------------------------------
package expr_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CMP    = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

    // Operand field widths (same layout on the a and b side)
    localparam int A0_W = 4;
    localparam int A1_W = 5;
    localparam int A2_W = 6;
    localparam int A3_W = 4;
    localparam int A4_W = 5;
    localparam int A5_W = 6;
    localparam int SIDE_W = A0_W + A1_W + A2_W + A3_W + A4_W + A5_W;

    // Field LSB offsets inside the 60-bit stimulus bus
    localparam int B5_OFF = 0;
    localparam int B4_OFF = B5_OFF + A5_W;
    localparam int B3_OFF = B4_OFF + A4_W;
    localparam int B2_OFF = B3_OFF + A3_W;
    localparam int B1_OFF = B2_OFF + A2_W;
    localparam int B0_OFF = B1_OFF + A1_W;
    localparam int A5_OFF = B0_OFF + A0_W;
    localparam int A4_OFF = A5_OFF + A5_W;
    localparam int A3_OFF = A4_OFF + A4_W;
    localparam int A2_OFF = A3_OFF + A3_W;
    localparam int A1_OFF = A2_OFF + A2_W;
    localparam int A0_OFF = A1_OFF + A1_W;

    localparam int LFSR_W = 64;

    // Taps 64,63,61,60 (1-based) -> bits 63,62,60,59
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 64'hD800_0000_0000_0000;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 64'h0000_0000_0000_0001;

    // Shift left, feedback is the XOR of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/expr_chk_lfsr.sv
// -----------------------------------------------------------------------------
// expr_chk_lfsr
// 64-bit Fibonacci LFSR with synchronous load and step.
// A zero seed would lock the register, so it is replaced by the default seed.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (state -> 64'h1)
//   load_i     load seed_i (zero replaced)
//   step_i     advance one step (load has priority)
//   seed_i     64-bit seed
//   next_o     low OUT_W bits of the value the register takes on the next step
// -----------------------------------------------------------------------------
module expr_chk_lfsr
    import expr_chk_pkg::*;
#(
    parameter int OUT_W = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [OUT_W-1:0]  next_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;
    logic [LFSR_W-1:0] next_s;

    // Next LFSR value and register update selection
    always_comb begin
        next_s  = lfsr_step(state_q);
        state_d = state_q;
        if (load_i) begin
            if (seed_i == '0) begin
                state_d = LFSR_DEFAULT_SEED;
            end else begin
                state_d = seed_i;
            end
        end else if (step_i) begin
            state_d = next_s;
        end else begin
            state_d = state_q;
        end
    end

    assign next_o = next_s[OUT_W-1:0];

    // LFSR state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LFSR_DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/expr_check_sequencer.sv
// -----------------------------------------------------------------------------
// expr_check_sequencer
// Drives pseudo-random operand vectors to a golden and a candidate expression
// block, waits SETTLE cycles, compares the two results and accumulates
// pass/fail statistics for the regression host.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               run request (IDLE only); num_vec/seed/stop_on_fail
//                       are sampled with it
//   abort               end the current run (ignored in IDLE, beats start)
//   stim                operand bus to both expression instances
//   y_ref, y_dut        golden / candidate results
//   busy, done, aborted run status (done is a one-cycle pulse)
//   vec_cnt, err_cnt    vectors compared / mismatches (saturating)
//   first_fail_*        index, stimulus and XOR diff of first mismatch
//   fail_seen           at least one mismatch this run
// All outputs are registered; results hold until the next accepted start.
// -----------------------------------------------------------------------------
module expr_check_sequencer
    import expr_chk_pkg::*;
#(
    parameter int STIM_W = 60,
    parameter int Y_W    = 90,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [LFSR_W-1:0] seed,
    input  logic              stop_on_fail,
    input  logic              abort,
    output logic [STIM_W-1:0] stim,
    input  logic [Y_W-1:0]    y_ref,
    input  logic [Y_W-1:0]    y_dut,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [STIM_W-1:0] first_fail_stim,
    output logic [Y_W-1:0]    first_fail_diff,
    output logic              fail_seen
);

    localparam int              SET_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
    localparam bit              HAS_SETTLE = (SETTLE > 0);

    state_e            state_q,   state_d;
    logic [SET_W-1:0]  settle_q,  settle_d;
    logic [CNT_W-1:0]  num_vec_q, num_vec_d;
    logic              stop_q,    stop_d;
    logic [STIM_W-1:0] stim_q,    stim_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              aborted_q, aborted_d;
    logic [CNT_W-1:0]  vec_q,     vec_d;
    logic [CNT_W-1:0]  err_q,     err_d;
    logic [CNT_W-1:0]  fidx_q,    fidx_d;
    logic [STIM_W-1:0] fstim_q,   fstim_d;
    logic [Y_W-1:0]    fdiff_q,   fdiff_d;
    logic              fseen_q,   fseen_d;

    logic              lfsr_load_s;
    logic              lfsr_step_s;
    logic [STIM_W-1:0] lfsr_next_s;
    logic              mismatch_s;
    logic [Y_W-1:0]    diff_s;

    expr_chk_lfsr #(
        .OUT_W (STIM_W)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load_s),
        .step_i (lfsr_step_s),
        .seed_i (seed),
        .next_o (lfsr_next_s)
    );

    // Result comparison between golden and candidate
    always_comb begin
        diff_s     = y_ref ^ y_dut;
        mismatch_s = (diff_s != '0);
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        num_vec_d   = num_vec_q;
        stop_d      = stop_q;
        stim_d      = stim_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        vec_d       = vec_q;
        err_d       = err_q;
        fidx_d      = fidx_q;
        fstim_d     = fstim_q;
        fdiff_d     = fdiff_q;
        fseen_d     = fseen_q;
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_vec_d   = num_vec;
                    stop_d      = stop_on_fail;
                    lfsr_load_s = 1'b1;
                    busy_d      = 1'b1;
                    aborted_d   = 1'b0;
                    vec_d       = '0;
                    err_d       = '0;
                    fidx_d      = '0;
                    fstim_d     = '0;
                    fdiff_d     = '0;
                    fseen_d     = 1'b0;
                    if (num_vec == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                lfsr_step_s = 1'b1;
                stim_d      = lfsr_next_s;
                settle_d    = '0;
                if (HAS_SETTLE) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_CMP;
                end
            end

            ST_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    state_d = ST_CMP;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end

            ST_CMP: begin
                vec_d = vec_q + CNT_W'(1);
                if (mismatch_s) begin
                    if (err_q != '1) begin
                        err_d = err_q + CNT_W'(1);
                    end else begin
                        err_d = err_q;
                    end
                    // Only the first mismatch of a run is captured
                    if (!fseen_q) begin
                        fidx_d  = vec_q;
                        fstim_d = stim_q;
                        fdiff_d = diff_s;
                        fseen_d = 1'b1;
                    end else begin
                        fseen_d = fseen_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if ((vec_d == num_vec_q) || (mismatch_s && stop_q)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides whatever the active state decided, including any
        // compare result in the same cycle; FIN already ends the run.
        if (abort && (state_q != ST_IDLE) && (state_q != ST_FIN)) begin
            state_d     = ST_FIN;
            aborted_d   = 1'b1;
            stim_d      = stim_q;
            vec_d       = vec_q;
            err_d       = err_q;
            fidx_d      = fidx_q;
            fstim_d     = fstim_q;
            fdiff_d     = fdiff_q;
            fseen_d     = fseen_q;
            lfsr_step_s = 1'b0;
        end else begin
            aborted_d = aborted_d;
        end
    end

    // State, counter and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            num_vec_q <= '0;
            stop_q    <= 1'b0;
            stim_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            vec_q     <= '0;
            err_q     <= '0;
            fidx_q    <= '0;
            fstim_q   <= '0;
            fdiff_q   <= '0;
            fseen_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            num_vec_q <= num_vec_d;
            stop_q    <= stop_d;
            stim_q    <= stim_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
            fidx_q    <= fidx_d;
            fstim_q   <= fstim_d;
            fdiff_q   <= fdiff_d;
            fseen_q   <= fseen_d;
        end
    end

    assign stim            = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign vec_cnt         = vec_q;
    assign err_cnt         = err_q;
    assign first_fail_idx  = fidx_q;
    assign first_fail_stim = fstim_q;
    assign first_fail_diff = fdiff_q;
    assign fail_seen       = fseen_q;

endmodule

// File: tb/tb_expr_check_sequencer.sv
// -----------------------------------------------------------------------------
// tb_expr_check_sequencer
// Scoreboard bench: each run pushes its expected end-of-run record into a
// queue; monitors pop and compare whenever a DUT pulses done.
// dut0: CNT_W=16, dut1: CNT_W=4 (counter saturation / mid-run reset).
// y_ref = {stim[29:0], stim}; y_dut = y_ref with bit 17 flipped when injected.
// With seed 1 (or 0) vector k stim is 1<<(k+1) for k<58; vector 63 is 60'h1B.
// -----------------------------------------------------------------------------
module tb_expr_check_sequencer;

    typedef struct {
        int          cyc;
        logic [15:0] vec;
        logic [15:0] err;
        logic [15:0] idx;
        logic [59:0] fstim;
        logic [89:0] fdiff;
        logic        fseen;
        logic        abrt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    exp_t q0[$];
    exp_t q1[$];

    // dut0 signals
    logic        start0 = 1'b0, stop0 = 1'b0, abort0 = 1'b0;
    logic [15:0] num_vec0 = 16'd0;
    logic [63:0] seed0 = 64'd0;
    logic [59:0] stim0, fstim0;
    logic [89:0] yref0, ydut0, fdiff0;
    logic        busy0, done0, abrt0, fseen0;
    logic [15:0] vec0, err0, fidx0;
    int          mode0 = 0;
    logic [59:0] tgt0 = 60'd0;

    // dut1 signals
    logic        start1 = 1'b0, stop1 = 1'b0, abort1 = 1'b0;
    logic [3:0]  num_vec1 = 4'd0;
    logic [63:0] seed1 = 64'd1;
    logic [59:0] stim1, fstim1;
    logic [89:0] yref1, ydut1, fdiff1;
    logic        busy1, done1, abrt1, fseen1;
    logic [3:0]  vec1, err1, fidx1;

    always_comb begin
        yref0 = {stim0[29:0], stim0};
        ydut0 = yref0;
        if (mode0 == 1 || (mode0 == 2 && stim0 == tgt0)) ydut0 = yref0 ^ 90'h20000;
        yref1 = {stim1[29:0], stim1};
        ydut1 = yref1 ^ 90'h20000;
    end

    expr_check_sequencer #(.STIM_W(60), .Y_W(90), .SETTLE(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .num_vec(num_vec0), .seed(seed0),
        .stop_on_fail(stop0), .abort(abort0), .stim(stim0), .y_ref(yref0), .y_dut(ydut0),
        .busy(busy0), .done(done0), .aborted(abrt0), .vec_cnt(vec0), .err_cnt(err0),
        .first_fail_idx(fidx0), .first_fail_stim(fstim0), .first_fail_diff(fdiff0),
        .fail_seen(fseen0));

    expr_check_sequencer #(.STIM_W(60), .Y_W(90), .SETTLE(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .num_vec(num_vec1), .seed(seed1),
        .stop_on_fail(stop1), .abort(abort1), .stim(stim1), .y_ref(yref1), .y_dut(ydut1),
        .busy(busy1), .done(done1), .aborted(abrt1), .vec_cnt(vec1), .err_cnt(err1),
        .first_fail_idx(fidx1), .first_fail_stim(fstim1), .first_fail_diff(fdiff1),
        .fail_seen(fseen1));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] v, input logic [15:0] e, input logic [15:0] i,
                                input logic [59:0] fs, input logic [89:0] fd,
                                input logic fsn, input logic ab);
        exp_t r;
        r.cyc = 0; r.vec = v; r.err = e; r.idx = i;
        r.fstim = fs; r.fdiff = fd; r.fseen = fsn; r.abrt = ab;
        return r;
    endfunction

    task automatic cmp_res(input string tg, input exp_t e, input logic [15:0] v,
                           input logic [15:0] er, input logic [15:0] ix, input logic [59:0] fs,
                           input logic [89:0] fd, input logic fsn, input logic ab, input logic bz);
        chk({tg, " done_cycle"}, cyc, e.cyc);
        chk({tg, " vec_cnt"}, v, e.vec);
        chk({tg, " err_cnt"}, er, e.err);
        chk({tg, " first_fail_idx"}, ix, e.idx);
        chk({tg, " first_fail_stim"}, fs, e.fstim);
        chk({tg, " first_fail_diff"}, fd, e.fdiff);
        chk({tg, " fail_seen"}, fsn, e.fseen);
        chk({tg, " aborted"}, ab, e.abrt);
        chk({tg, " busy_at_done"}, bz, 1'b0);
    endtask

    task automatic chk_rst(input string tg, input logic [59:0] s, input logic bz, input logic dn,
                           input logic ab, input logic [15:0] v, input logic [15:0] er,
                           input logic [15:0] ix, input logic [59:0] fs, input logic [89:0] fd,
                           input logic fsn);
        chk({tg, " stim"}, s, 60'd0);
        chk({tg, " busy"}, bz, 1'b0);
        chk({tg, " done"}, dn, 1'b0);
        chk({tg, " aborted"}, ab, 1'b0);
        chk({tg, " vec_cnt"}, v, 16'd0);
        chk({tg, " err_cnt"}, er, 16'd0);
        chk({tg, " first_fail_idx"}, ix, 16'd0);
        chk({tg, " first_fail_stim"}, fs, 60'd0);
        chk({tg, " first_fail_diff"}, fd, 90'd0);
        chk({tg, " fail_seen"}, fsn, 1'b0);
    endtask

    // Monitor for dut0 end-of-run records
    initial begin : mon0
        exp_t e;
        forever begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                if (q0.size() == 0) begin
                    chk("dut0 unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = q0.pop_front();
                    cmp_res("dut0", e, vec0, err0, fidx0, fstim0, fdiff0, fseen0, abrt0, busy0);
                end
            end
        end
    end

    // Monitor for dut1 end-of-run records
    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    chk("dut1 unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = q1.pop_front();
                    cmp_res("dut1", e, {12'd0, vec1}, {12'd0, err1}, {12'd0, fidx1},
                            fstim1, fdiff1, fseen1, abrt1, busy1);
                end
            end
        end
    end

    // One dut0 run; off = expected done cycle relative to the start cycle
    task automatic run0(input logic [15:0] n, input logic [63:0] sd, input logic stop,
                        input int mode, input logic [59:0] tgt, input int off,
                        input int abort_at, input int restart_at, input exp_t e);
        int   t;
        exp_t ee;
        @(negedge clk);
        mode0 = mode; tgt0 = tgt; num_vec0 = n; seed0 = sd; stop0 = stop; start0 = 1'b1;
        t = cyc;
        ee = e;
        ee.cyc = t + off;
        q0.push_back(ee);
        for (int rel = 1; rel <= off + 20; rel++) begin
            @(negedge clk);
            start0   = (rel == restart_at);
            num_vec0 = (rel == restart_at) ? 16'd1 : n;
            abort0   = (rel == abort_at);
            if (rel == 1) chk("dut0 busy_rise", busy0, 1'b1);
            if (rel == 2 && n != 16'd0) chk("dut0 first_stim", stim0, 60'h2);
            if (q0.size() == 0) break;
        end
        start0 = 1'b0;
        abort0 = 1'b0;
        if (q0.size() != 0) begin
            chk("dut0 done_timeout", q0.size(), 0);
            q0.delete();
        end
    endtask

    initial begin : stim_main
        exp_t e;
        int   t;
        repeat (2) @(negedge clk);
        chk_rst("reset0", stim0, busy0, done0, abrt0, vec0, err0, fidx0, fstim0, fdiff0, fseen0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 100 clean vectors
        run0(16'd100, 64'd1, 1'b0, 0, 60'd0, 402, 0, 0,
             mk(16'd100, 16'd0, 16'd0, 60'd0, 90'd0, 1'b0, 1'b0));
        // single injected mismatch at vector 5 (stim 60'h40)
        run0(16'd10, 64'd1, 1'b0, 2, 60'h40, 42, 0, 0,
             mk(16'd10, 16'd1, 16'd5, 60'h40, 90'h20000, 1'b1, 1'b0));
        // permanent mismatch, stop on first fail
        run0(16'd50, 64'd1, 1'b1, 1, 60'd0, 6, 0, 0,
             mk(16'd1, 16'd1, 16'd0, 60'h2, 90'h20000, 1'b1, 1'b0));
        // abort in the first SETTLE cycle of vector 3
        run0(16'd10, 64'd1, 1'b0, 0, 60'd0, 16, 14, 0,
             mk(16'd3, 16'd0, 16'd0, 60'd0, 90'd0, 1'b0, 1'b1));
        // abort while idle is ignored
        @(negedge clk); abort0 = 1'b1;
        @(negedge clk); abort0 = 1'b0;
        chk("dut0 idle_abort_busy", busy0, 1'b0);
        // normal run after the abort
        run0(16'd2, 64'd1, 1'b0, 0, 60'd0, 10, 0, 0,
             mk(16'd2, 16'd0, 16'd0, 60'd0, 90'd0, 1'b0, 1'b0));
        // zero vectors with zero seed
        run0(16'd0, 64'd0, 1'b0, 0, 60'd0, 2, 0, 0,
             mk(16'd0, 16'd0, 16'd0, 60'd0, 90'd0, 1'b0, 1'b0));
        // zero seed follows the seed-1 sequence past the feedback taps
        // (vector 63 stim = 60'h1B); a start while busy is ignored
        run0(16'd70, 64'd0, 1'b0, 2, 60'h1B, 282, 0, 20,
             mk(16'd70, 16'd1, 16'd63, 60'h1B, 90'h20000, 1'b1, 1'b0));

        // dut1: 4-bit counters, 15 permanent mismatches
        @(negedge clk);
        num_vec1 = 4'd15; seed1 = 64'd1; stop1 = 1'b0; start1 = 1'b1;
        t = cyc;
        e = mk(16'd15, 16'd15, 16'd0, 60'h2, 90'h20000, 1'b1, 1'b0);
        e.cyc = t + 62;
        q1.push_back(e);
        @(negedge clk); start1 = 1'b0;
        for (int i = 0; i < 90; i++) begin
            if (q1.size() == 0) break;
            @(negedge clk);
        end
        if (q1.size() != 0) begin
            chk("dut1 done_timeout", q1.size(), 0);
            q1.delete();
        end

        // dut1: reset in the middle of a run
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (20) @(negedge clk);
        chk("dut1 busy_before_rst", busy1, 1'b1);
        #2 rst = 1'b1;
        #1 chk_rst("midrun_rst1", stim1, busy1, done1, abrt1, {12'd0, vec1}, {12'd0, err1},
                   {12'd0, fidx1}, fstim1, fdiff1, fseen1);
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
